// File: rtl/int_ctrl_if.sv
// Controller-side bus of the interrupt sequencer: request inputs, control strobes,
// PC-slice strobes and debug visibility of the sequencer state.
interface int_ctrl_if;
  logic        Test;
  logic [3:0]  Irq;
  logic [15:0] SysBus;
  logic        MaskWe;
  logic        Ei;
  logic        Di;
  logic        Reti;
  logic        InstrBoundary;

  logic        IntTake;
  logic        LrWe;
  logic        LrSelPc;
  logic        PcWe;
  logic        PcSelInt;
  logic [15:0] PCI_Value;
  logic        IntAck;
  logic [1:0]  IntId;
  logic        InService;

  logic [1:0]  dbgState;
  logic [3:0]  dbgPending;
  logic        dbgIntEn;

  // Handshake: there is no valid/ready pair. IntTake is a stall level that is high
  // for exactly the three sequence cycles; LrWe, PcWe and IntAck are one-cycle strobes
  // issued in that order, and the controller must hold its pipeline while IntTake=1.
  modport master (
    output Test, Irq, SysBus, MaskWe, Ei, Di, Reti, InstrBoundary,
    input  IntTake, LrWe, LrSelPc, PcWe, PcSelInt, PCI_Value, IntAck, IntId, InService,
    input  dbgState, dbgPending, dbgIntEn
  );

  modport slave (
    input  Test, Irq, SysBus, MaskWe, Ei, Di, Reti, InstrBoundary,
    output IntTake, LrWe, LrSelPc, PcWe, PcSelInt, PCI_Value, IntAck, IntId, InService,
    output dbgState, dbgPending, dbgIntEn
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-source prioritised interrupt sequencer: synchronises requests, latches them as
// pending, and runs a fixed SAVE/VECTOR/ACK sequence at an instruction boundary.
module int_ctrl (
  input  logic      Clock,
  input  logic      nReset,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    VECTOR = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] irqMeta;
  logic [3:0] irqSync;
  logic [3:0] irqPrev;
  logic [3:0] irqRise;
  logic [3:0] pending;
  logic [3:0] intMask;
  logic [3:0] eligible;
  logic [3:0] ackClr;
  logic       intEn;
  logic       inService;
  logic [1:0] intId;
  logic [1:0] winner;
  logic       take;

  logic       intTake;
  logic       lrWe;
  logic       lrSelPc;
  logic       pcWe;
  logic       pcSelInt;
  logic       intAck;

  // Scan select and the upper bus bits have no function in this block.
  logic       unusedBits;
  assign unusedBits = ^{bus.Test, bus.SysBus[15:4]};

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      irqMeta <= 4'd0;
      irqSync <= 4'd0;
      irqPrev <= 4'd0;
    end else begin
      irqMeta <= bus.Irq;
      irqSync <= irqMeta;
      irqPrev <= irqSync;
    end
  end

  assign irqRise  = irqSync & ~irqPrev;
  assign eligible = pending & intMask;

  always_comb begin
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
    else                  winner = 2'd3;
  end

  assign take = (state == IDLE) && bus.InstrBoundary && intEn && (eligible != 4'd0);

  // Service bookkeeping lands on the VECTOR->ACK edge so it is visible during ACK.
  assign ackClr = (state == VECTOR) ? (4'b0001 << intId) : 4'b0000;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pending   <= 4'd0;
      intMask   <= 4'd0;
      intEn     <= 1'b0;
      inService <= 1'b0;
    end else begin
      pending <= (pending & ~ackClr) | irqRise;
      if (bus.MaskWe)
        intMask <= bus.SysBus[3:0];
      if (bus.Di)
        intEn <= 1'b0;
      else if (state == VECTOR)
        intEn <= 1'b0;
      else if ((state == IDLE) && (bus.Ei || bus.Reti))
        intEn <= 1'b1;
      if (state == VECTOR)
        inService <= 1'b1;
      else if ((state == IDLE) && bus.Reti)
        inService <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      intId    <= 2'd0;
      intTake  <= 1'b0;
      lrWe     <= 1'b0;
      lrSelPc  <= 1'b0;
      pcWe     <= 1'b0;
      pcSelInt <= 1'b0;
      intAck   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state   <= SAVE;
            intId   <= winner;
            intTake <= 1'b1;
            lrWe    <= 1'b1;
            lrSelPc <= 1'b1;
          end
        end
        SAVE: begin
          state    <= VECTOR;
          lrWe     <= 1'b0;
          lrSelPc  <= 1'b0;
          pcWe     <= 1'b1;
          pcSelInt <= 1'b1;
        end
        VECTOR: begin
          state    <= ACK;
          pcWe     <= 1'b0;
          pcSelInt <= 1'b0;
          intAck   <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          intAck  <= 1'b0;
          intTake <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IntTake    = intTake;
  assign bus.LrWe       = lrWe;
  assign bus.LrSelPc    = lrSelPc;
  assign bus.PcWe       = pcWe;
  assign bus.PcSelInt   = pcSelInt;
  assign bus.IntAck     = intAck;
  assign bus.IntId      = intId;
  assign bus.InService  = inService;
  // intId is frozen for the whole sequence, so the vector is stable SAVE..ACK.
  assign bus.PCI_Value  = 16'h0010 + {12'd0, intId, 2'b00};
  assign bus.dbgState   = state;
  assign bus.dbgPending = pending;
  assign bus.dbgIntEn   = intEn;

endmodule
